// File: rtl/frame_source.sv
// -----------------------------------------------------------------------------
// frame_source
//   APB-configured frame generator. Emits frames of LEN beats on a
//   valid/ready/eof stream. Data is either a count pattern (SEED + pos) or,
//   when built with FRAME_SOURCE_LFSR_EN, a Galois right-shift LFSR seeded
//   with SEED. Latches the checksum of the last frame, a running frame count
//   and a sticky end-of-frame interrupt.
//
//   Optional feature macro: FRAME_SOURCE_LFSR_EN (enables CTRL.mode / LFSR).
//
// Ports
//   clk, rst_n       clock (rising edge), async active-low reset
//   cfg_paddr/...    APB slave: paddr[4:2] word address, pready=1, pslverr=0,
//                    read data registered one cycle after the setup phase
//   cfg_irq          sticky end-of-frame interrupt
//   dout_valid/ready stream handshake
//   dout_data        stream data, DataBits wide (8, 16 or 32)
//   dout_eof         last beat of the frame
//
// Word map: 0 CTRL {mode,enable}, 1 LEN, 2 NFRAMES, 3 STATUS {busy,ready,valid},
//           4 CHECKSUM, 5 FRAMECOUNT, 6 IRQ, 7 SEED
// -----------------------------------------------------------------------------
module frame_source #(
    parameter int DataBits = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4:0]          cfg_paddr,
    input  logic                cfg_pwrite,
    input  logic [31:0]         cfg_pwdata,
    input  logic                cfg_psel,
    input  logic                cfg_penable,
    output logic                cfg_pready,
    output logic [31:0]         cfg_prdata,
    output logic                cfg_pslverr,
    output logic                cfg_irq,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic [DataBits-1:0] dout_data,
    output logic                dout_eof
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t state, next_state;

    // Programmed registers (take effect at the next frame boundary)
    logic                ctrl_enable;
    logic [15:0]         len_reg;
    logic [15:0]         nframes_reg;
    logic [DataBits-1:0] seed_reg;
    logic [31:0]         checksum;
    logic [31:0]         framecount;

    // Per-frame working copies
    logic [15:0]         f_len;
    logic [15:0]         f_nframes;
    logic [DataBits-1:0] f_seed;
    logic [15:0]         pos;
    logic [15:0]         sent;
    logic [31:0]         acc;

    logic [2:0]  word;
    logic        wr, rd;
    logic [15:0] len_eff;
    logic        accept, eof_beat, last_frame, frame_done;
    logic [DataBits-1:0] pattern;
    logic [31:0] data_ext;
    logic        unused_bits;

    assign word    = cfg_paddr[4:2];
    assign wr      = cfg_psel & ~cfg_penable & cfg_pwrite;
    assign rd      = cfg_psel & ~cfg_penable & ~cfg_pwrite;
    assign len_eff = (len_reg == 16'd0) ? 16'd1 : len_reg;

    assign cfg_pready  = 1'b1;
    assign cfg_pslverr = 1'b0;
    assign unused_bits = ^{cfg_pwdata[31:16], cfg_paddr[1:0]};

`ifdef FRAME_SOURCE_LFSR_EN
    localparam logic [31:0] Taps = (DataBits == 8)  ? 32'h0000_00B8 :
                                   (DataBits == 16) ? 32'h0000_B400 :
                                                      32'h8020_0003;
    logic                ctrl_mode;
    logic                f_mode;
    logic [DataBits-1:0] lfsr;
    logic [DataBits-1:0] lfsr_next;
    logic [DataBits-1:0] lfsr_seed;

    assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ Taps[DataBits-1:0]) : (lfsr >> 1);
    assign lfsr_seed = (seed_reg == '0) ? DataBits'(1) : seed_reg;
    assign pattern   = f_mode ? lfsr : (f_seed + DataBits'(pos));
`else
    assign pattern   = f_seed + DataBits'(pos);
`endif

    assign dout_valid = (state == RUN);
    assign dout_eof   = (state == RUN) && (pos == f_len - 16'd1);
    assign dout_data  = dout_valid ? pattern : '0;
    assign data_ext   = 32'(dout_data);

    assign accept     = dout_valid & dout_ready;
    assign eof_beat   = accept & dout_eof;
    assign last_frame = (f_nframes != 16'd0) && (sent + 16'd1 == f_nframes);
    assign frame_done = eof_beat & (~ctrl_enable | last_frame);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: next_state gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ctrl_enable) next_state = LOAD;
            LOAD:    next_state = RUN;
            RUN:     if (frame_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Configuration registers; completion of NFRAMES overrides a same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_enable <= 1'b0;
            len_reg     <= '0;
            nframes_reg <= '0;
            seed_reg    <= '0;
`ifdef FRAME_SOURCE_LFSR_EN
            ctrl_mode   <= 1'b0;
`endif
        end else begin
            if (wr) begin
                case (word)
                    3'd0: begin
                        ctrl_enable <= cfg_pwdata[0];
`ifdef FRAME_SOURCE_LFSR_EN
                        ctrl_mode   <= cfg_pwdata[1];
`endif
                    end
                    3'd1:    len_reg     <= cfg_pwdata[15:0];
                    3'd2:    nframes_reg <= cfg_pwdata[15:0];
                    3'd7:    seed_reg    <= cfg_pwdata[DataBits-1:0];
                    default: ;
                endcase
            end
            if (eof_beat && last_frame) ctrl_enable <= 1'b0;
        end
    end

    // Interrupt: an eof beat beats a same-cycle clearing write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    cfg_irq <= 1'b0;
        else if (eof_beat)             cfg_irq <= 1'b1;
        else if (wr && word == 3'd6)   cfg_irq <= cfg_pwdata[0];
    end

    // Frame datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_len      <= '0;
            f_nframes  <= '0;
            f_seed     <= '0;
            pos        <= '0;
            sent       <= '0;
            acc        <= '0;
            checksum   <= '0;
            framecount <= '0;
`ifdef FRAME_SOURCE_LFSR_EN
            f_mode     <= 1'b0;
            lfsr       <= '0;
`endif
        end else if (state == LOAD) begin
            f_len     <= len_eff;
            f_nframes <= nframes_reg;
            f_seed    <= seed_reg;
            pos       <= '0;
            sent      <= '0;
            acc       <= '0;
`ifdef FRAME_SOURCE_LFSR_EN
            f_mode    <= ctrl_mode;
            lfsr      <= lfsr_seed;
`endif
        end else if (accept) begin
            if (dout_eof) begin
                // Frame boundary: publish results and re-sample the shape of the next frame.
                checksum   <= acc + data_ext;
                acc        <= '0;
                pos        <= '0;
                sent       <= sent + 16'd1;
                framecount <= framecount + 32'd1;
                f_len      <= len_eff;
                f_seed     <= seed_reg;
`ifdef FRAME_SOURCE_LFSR_EN
                f_mode     <= ctrl_mode;
                lfsr       <= lfsr_seed;
`endif
            end else begin
                acc <= acc + data_ext;
                pos <= pos + 16'd1;
`ifdef FRAME_SOURCE_LFSR_EN
                lfsr <= lfsr_next;
`endif
            end
        end
    end

    // Registered read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_prdata <= '0;
        end else if (rd) begin
            case (word)
`ifdef FRAME_SOURCE_LFSR_EN
                3'd0: cfg_prdata <= {30'd0, ctrl_mode, ctrl_enable};
`else
                3'd0: cfg_prdata <= {31'd0, ctrl_enable};
`endif
                3'd1: cfg_prdata <= {16'd0, len_reg};
                3'd2: cfg_prdata <= {16'd0, nframes_reg};
                3'd3: cfg_prdata <= {29'd0, (state != IDLE), dout_ready, dout_valid};
                3'd4: cfg_prdata <= checksum;
                3'd5: cfg_prdata <= framecount;
                3'd6: cfg_prdata <= {31'd0, cfg_irq};
                3'd7: cfg_prdata <= 32'(seed_reg);
            endcase
        end
    end

endmodule
